prog_loader: RTL and testbench
==============================

# prog_loader

Instruction encoder and instruction-memory loader for the modified MIPS core. It accepts symbolic instruction requests over a valid/ready handshake and packs each into a 32-bit word using the core's opcode map. It writes the words sequentially into instruction memory through an acknowledged write port. It sits beside the instruction memory and is used for boot and self-test program loading, producing exactly what the control unit decodes.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `DEPTH`, 1024: words available; last writable address is DEPTH-1.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: loader can accept a request.
- `req_mnem` in 5: mnemonic code (package enum).
- `req_rs`, `req_rt`, `req_rd`, `req_shamt` in 5 each: register/shift fields. For FP instructions they are fmt, ft, fs, fd.
- `req_fun` in 6: R/FR function field.
- `req_imm` in 16: immediate or branch offset.
- `req_target` in 26: jump target.
- `clear` in 1: synchronous restart. Address goes to 0 and `full` clears.
- `imem_we` out 1: write strobe, held until ack.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: encoded word.
- `imem_ack` in 1: write (or read) accepted this cycle.
- `count` out ADDR_W+1: words written since reset or clear.
- `full` out 1: memory filled; no further requests accepted.
- `bad_op` out 1: one-cycle pulse when an unknown mnemonic is accepted.

## Operation
- **Opcode map**
  - RTYPE 000011
  - ADDI 001001, ANDI 001100, ORI 001110
  - BEQ 000101, BNE 000100
  - J 000010
  - LBU 100010, LUI 001111, LW 010010
  - SB 101000, SW 101011
  - FP 010001
  - LWC1 110001, LDC1 110101, SWC1 111001, SDC1 111101
- **Field packing**
  - RTYPE and FP: op, rs, rt, rd, shamt, fun packed into bits [31:26], [25:21], [20:16], [15:11], [10:6], [5:0].
  - Immediate and branch classes, including BC1 (FP with rs=01000): op, rs, rt, imm.
  - J: op plus target.
  - For LUI, `req_rs` is forced to 0.
- **FSM states:** IDLE, WR, FULL. RDBK and CHK exist only when readback is compiled in.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the word is encoded and registered into `imem_wdata`, and the FSM goes to WR.
  - If the mnemonic is unknown: pulse `bad_op` the next cycle, stay in IDLE, write nothing, leave `count` unchanged.
- **WR**
  - `imem_we`=1, with address and data stable until `imem_ack`.
  - On ack: `count`+1.
  - If `imem_addr`==DEPTH-1, go to FULL. Otherwise `imem_addr`+1 and return to IDLE.
- **FULL:** `full`=1 and `req_ready`=0 until `clear`.
- **clear**
  - Takes effect in any state, including mid-WR: `imem_we` drops next cycle and the pending write is abandoned.
  - State goes to IDLE; `imem_addr` and `count` go to 0.
- **Simultaneous events:** if `clear` and `req_valid` occur in the same cycle, `clear` wins and the request is not accepted.
- **Reset values**
  - State IDLE, so `req_ready`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `full`=0, `bad_op`=0.
- `rst` mid-write abandons the write immediately; the memory side must tolerate a dropped strobe.

## Timing
- Request accepted at edge t: `imem_we` is high from t+1.
- With ack at t+1: `req_ready` is high again at t+2. Steady-state throughput is one word per 2 cycles.
- `req_ready` is a Moore output (state==IDLE), so there is no combinational valid-to-ready path.
- `imem_ack` outside WR/RDBK is ignored.
- `count` saturates at DEPTH; it never wraps.

## Configuration
- **`PROG_LOADER_READBACK_EN` defined**
  - Adds an `imem_re` output and an `imem_rdata` 32-bit input.
  - After a WR ack, the FSM goes to RDBK and asserts `imem_re` until ack.
  - CHK then compares `imem_rdata` (valid the cycle after the read ack) to the written word.
  - On a mismatch, a sticky `verify_err` output is set; it clears only on `clear` or `rst`.
  - Throughput becomes one word per 4 cycles minimum.
- **Undefined:** no readback ports or states; WR returns directly to IDLE or FULL.

## Structure
- **Shared package `mips_isa_pkg`:** mnemonic enum, 6-bit opcode constants, FP fmt constants (SINGLE 10000, DOUBLE 10001, BC 01000). The control unit uses the same package.
- **Sub-module `instr_packer`:** purely combinational (mnemonic and fields in; word and valid flag out). It is reused by the bench as a reference model.

## Test plan
- **ADDI** rs=2, rt=3, imm=0x0010 with ack next cycle: `imem_wdata`=0x24430010 at addr 0; `count`=1; `req_ready` high 2 cycles after accept.
- **RTYPE** rs=1, rt=2, rd=4, fun=0x20, then **J** target=0x100: words 0x0C222020 at addr 0 and 0x08000100 at addr 1.
- **FP add.s**, fmt=10000, ft=2, fs=4, fd=6, fun=0: word 0x46022180.
- **Unknown mnemonic 31:** `bad_op` pulses once, `imem_we` stays 0, `count` unchanged.
- **Full/clear:** with DEPTH=4, after four writes `full`=1 and `req_ready`=0. A fifth `req_valid` is ignored. `clear` then gives addr 0, `count` 0, `req_ready` 1.
- **Stall and reset:** hold `imem_ack` low for 5 cycles and check address/data are stable. Assert `rst` mid-WR: next edge `imem_we`=0 and all outputs are at reset values.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared ISA definitions for the modified MIPS core.
// Holds the mnemonic enum, the 6-bit opcode map, the FP fmt codes and the
// field-packing class used by the instruction packer. The control unit decodes
// from the same constants, so the loader and the core cannot drift apart.
package mips_isa_pkg;

  // Symbolic mnemonics carried on the loader request channel. Codes not
  // listed here (e.g. 31) are treated as unknown.
  typedef enum logic [4:0] {
    MnRtype = 5'd0,
    MnAddi  = 5'd1,
    MnAndi  = 5'd2,
    MnOri   = 5'd3,
    MnBeq   = 5'd4,
    MnBne   = 5'd5,
    MnJ     = 5'd6,
    MnLbu   = 5'd7,
    MnLui   = 5'd8,
    MnLw    = 5'd9,
    MnSb    = 5'd10,
    MnSw    = 5'd11,
    MnFp    = 5'd12,
    MnLwc1  = 5'd13,
    MnLdc1  = 5'd14,
    MnSwc1  = 5'd15,
    MnSdc1  = 5'd16
  } mnem_e;

  // Opcode map of the modified core (not the stock MIPS encoding).
  localparam logic [5:0] OpRtype = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001110;
  localparam logic [5:0] OpBeq   = 6'b000101;
  localparam logic [5:0] OpBne   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpLbu   = 6'b100010;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b010010;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpFp    = 6'b010001;
  localparam logic [5:0] OpLwc1  = 6'b110001;
  localparam logic [5:0] OpLdc1  = 6'b110101;
  localparam logic [5:0] OpSwc1  = 6'b111001;
  localparam logic [5:0] OpSdc1  = 6'b111101;

  // FP fmt field values (occupy the rs slot of FP instructions).
  localparam logic [4:0] FmtSingle = 5'b10000;
  localparam logic [4:0] FmtDouble = 5'b10001;
  localparam logic [4:0] FmtBc     = 5'b01000;

  // How the fields of a request are packed into the 32-bit word.
  typedef enum logic [1:0] {
    ClsReg,   // op rs rt rd shamt fun
    ClsImm,   // op rs rt imm16
    ClsJump   // op target26
  } cls_e;

endpackage

// File: rtl/instr_packer.sv
// instr_packer: purely combinational instruction encoder.
// Ports:
//   mnem_i      mnemonic code (mips_isa_pkg::mnem_e values)
//   rs_i..fun_i register/shift/function fields (fmt/ft/fs/fd for FP)
//   imm_i       16-bit immediate or branch offset
//   target_i    26-bit jump target
//   word_o      encoded 32-bit instruction word
//   valid_o     1 when mnem_i is a known mnemonic
module instr_packer
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  fun_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic [5:0] op;
  logic [4:0] rs;
  cls_e       cls;

  always_comb begin
    op      = OpRtype;
    cls     = ClsImm;
    valid_o = 1'b1;
    case (mnem_i)
      MnRtype: cls = ClsReg;
      MnAddi:  op  = OpAddi;
      MnAndi:  op  = OpAndi;
      MnOri:   op  = OpOri;
      MnBeq:   op  = OpBeq;
      MnBne:   op  = OpBne;
      MnLbu:   op  = OpLbu;
      MnLui:   op  = OpLui;
      MnLw:    op  = OpLw;
      MnSb:    op  = OpSb;
      MnSw:    op  = OpSw;
      MnLwc1:  op  = OpLwc1;
      MnLdc1:  op  = OpLdc1;
      MnSwc1:  op  = OpSwc1;
      MnSdc1:  op  = OpSdc1;
      MnJ: begin
        op  = OpJ;
        cls = ClsJump;
      end
      MnFp: begin
        op = OpFp;
        // BC1 branches carry an offset; every other FP op is register form.
        if (rs_i != FmtBc) cls = ClsReg;
      end
      default: valid_o = 1'b0;
    endcase

    rs = (mnem_i == MnLui) ? 5'd0 : rs_i;

    unique case (cls)
      ClsReg:  word_o = {op, rs, rt_i, rd_i, shamt_i, fun_i};
      ClsImm:  word_o = {op, rs, rt_i, imm_i};
      ClsJump: word_o = {op, target_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: encodes symbolic instruction requests and writes them
// sequentially into instruction memory.
// Build option: define PROG_LOADER_READBACK_EN to read every word back after
// writing it and flag mismatches on verify_err_o.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*_i / req_ready_o valid/ready request channel (mnemonic + fields)
//   clear_i               synchronous restart: address/count to 0, full clears
//   imem_we_o/addr_o/wdata_o, imem_ack_i  acknowledged write port
//   count_o               words written since reset or clear (saturates)
//   full_o                last address written; requests blocked until clear
//   bad_op_o              one-cycle pulse after an unknown mnemonic is taken
//   imem_re_o, imem_rdata_i, verify_err_o  readback build only
module prog_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_mnem_i,
  input  logic [4:0]        req_rs_i,
  input  logic [4:0]        req_rt_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_shamt_i,
  input  logic [5:0]        req_fun_i,
  input  logic [15:0]       req_imm_i,
  input  logic [25:0]       req_target_i,
  input  logic              clear_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ack_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              bad_op_o
`ifdef PROG_LOADER_READBACK_EN
  ,
  output logic              imem_re_o,
  input  logic [31:0]       imem_rdata_i,
  output logic              verify_err_o
`endif
);

  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StFull
`ifdef PROG_LOADER_READBACK_EN
    ,
    StRdbk,
    StChk
`endif
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              full_q;
  logic              bad_op_q;
`ifdef PROG_LOADER_READBACK_EN
  logic              imem_re_q;
  logic              verify_err_q;
`endif

  logic [31:0] enc_word;
  logic        enc_valid;

  instr_packer u_instr_packer (
    .mnem_i   (req_mnem_i),
    .rs_i     (req_rs_i),
    .rt_i     (req_rt_i),
    .rd_i     (req_rd_i),
    .shamt_i  (req_shamt_i),
    .fun_i    (req_fun_i),
    .imm_i    (req_imm_i),
    .target_i (req_target_i),
    .word_o   (enc_word),
    .valid_o  (enc_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      imem_we_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      bad_op_q     <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
      imem_re_q    <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      bad_op_q <= 1'b0;
      // clear overrides everything, including an accept in the same cycle
      // and a write still waiting for its ack.
      if (clear_i) begin
        state_q      <= StIdle;
        req_ready_q  <= 1'b1;
        imem_we_q    <= 1'b0;
        addr_q       <= '0;
        count_q      <= '0;
        full_q       <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
        imem_re_q    <= 1'b0;
        verify_err_q <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req_valid_i) begin
              if (enc_valid) begin
                wdata_q     <= enc_word;
                imem_we_q   <= 1'b1;
                req_ready_q <= 1'b0;
                state_q     <= StWr;
              end else begin
                bad_op_q <= 1'b1;
              end
            end
          end
          StWr: begin
            if (imem_ack_i) begin
              imem_we_q <= 1'b0;
              if (count_q != CountMax) count_q <= count_q + 1'b1;
`ifdef PROG_LOADER_READBACK_EN
              imem_re_q <= 1'b1;
              state_q   <= StRdbk;
`else
              if (addr_q == AddrLast) begin
                full_q  <= 1'b1;
                state_q <= StFull;
              end else begin
                addr_q      <= addr_q + 1'b1;
                req_ready_q <= 1'b1;
                state_q     <= StIdle;
              end
`endif
            end
          end
`ifdef PROG_LOADER_READBACK_EN
          StRdbk: begin
            if (imem_ack_i) begin
              imem_re_q <= 1'b0;
              state_q   <= StChk;
            end
          end
          StChk: begin
            // Read data arrives the cycle after the read ack.
            if (imem_rdata_i != wdata_q) verify_err_q <= 1'b1;
            if (addr_q == AddrLast) begin
              full_q  <= 1'b1;
              state_q <= StFull;
            end else begin
              addr_q      <= addr_q + 1'b1;
              req_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
`endif
          StFull: ;
          default: begin
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        endcase
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign bad_op_o     = bad_op_q;
`ifdef PROG_LOADER_READBACK_EN
  assign imem_re_o    = imem_re_q;
  assign verify_err_o = verify_err_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (DEPTH=4).
module tb_prog_loader;
  import mips_isa_pkg::*;

  localparam int unsigned AddrW = 10;
  localparam int unsigned Depth = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [4:0]       req_mnem = '0;
  logic [4:0]       req_rs = '0;
  logic [4:0]       req_rt = '0;
  logic [4:0]       req_rd = '0;
  logic [4:0]       req_shamt = '0;
  logic [5:0]       req_fun = '0;
  logic [15:0]      req_imm = '0;
  logic [25:0]      req_target = '0;
  logic             clear = 1'b0;
  logic             imem_we;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_wdata;
  logic             imem_ack = 1'b0;
  logic [AddrW:0]   count;
  logic             full;
  logic             bad_op;
`ifdef PROG_LOADER_READBACK_EN
  logic             imem_re;
  logic             verify_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W (AddrW),
    .DEPTH  (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_mnem_i   (req_mnem),
    .req_rs_i     (req_rs),
    .req_rt_i     (req_rt),
    .req_rd_i     (req_rd),
    .req_shamt_i  (req_shamt),
    .req_fun_i    (req_fun),
    .req_imm_i    (req_imm),
    .req_target_i (req_target),
    .clear_i      (clear),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .imem_ack_i   (imem_ack),
    .count_o      (count),
    .full_o       (full),
    .bad_op_o     (bad_op)
`ifdef PROG_LOADER_READBACK_EN
    ,
    .imem_re_o    (imem_re),
    .imem_rdata_i (imem_wdata),
    .verify_err_o (verify_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fun,
                         input logic [15:0] imm, input logic [25:0] tgt);
    req_mnem   = mn;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_shamt  = sh;
    req_fun    = fun;
    req_imm    = imm;
    req_target = tgt;
  endtask

  // Present a request for exactly one edge.
  task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fun,
                      input logic [15:0] imm, input logic [25:0] tgt);
    set_req(mn, rs, rt, rd, sh, fun, imm, tgt);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack_once();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_we"}, 32'(imem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_full"}, 32'(full), 32'd0);
    check_eq({tag, "_bad_op"}, 32'(bad_op), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // ADDI rs=2 rt=3 imm=0x10, acked the cycle after accept.
    send(MnAddi, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
    check_eq("addi_we", 32'(imem_we), 32'd1);
    check_eq("addi_ready_busy", 32'(req_ready), 32'd0);
    check_eq("addi_addr", 32'(imem_addr), 32'd0);
    check_eq("addi_word", imem_wdata, 32'h24430010);
    ack_once();
    check_eq("addi_we_drop", 32'(imem_we), 32'd0);
    check_eq("addi_count", 32'(count), 32'd1);
    check_eq("addi_ready_again", 32'(req_ready), 32'd1);
    check_eq("addi_next_addr", 32'(imem_addr), 32'd1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear1_addr", 32'(imem_addr), 32'd0);
    check_eq("clear1_count", 32'(count), 32'd0);

    // RTYPE then J.
    send(MnRtype, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20, 16'h0000, 26'd0);
    check_eq("rtype_addr", 32'(imem_addr), 32'd0);
    check_eq("rtype_word", imem_wdata, 32'h0C222020);
    ack_once();
    send(MnJ, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h100);
    check_eq("j_addr", 32'(imem_addr), 32'd1);
    check_eq("j_word", imem_wdata, 32'h08000100);
    ack_once();
    check_eq("j_count", 32'(count), 32'd2);

    // FP add.s: fmt=single ft=2 fs=4 fd=6 fun=0.
    send(MnFp, 5'b10000, 5'd2, 5'd4, 5'd6, 6'd0, 16'h0000, 26'd0);
    check_eq("fp_addr", 32'(imem_addr), 32'd2);
    check_eq("fp_word", imem_wdata, 32'h46022180);
    ack_once();
    check_eq("fp_count", 32'(count), 32'd3);

    // Unknown mnemonic 31.
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234, 26'd0);
    check_eq("bad_pulse", 32'(bad_op), 32'd1);
    check_eq("bad_no_we", 32'(imem_we), 32'd0);
    check_eq("bad_ready", 32'(req_ready), 32'd1);
    tick();
    check_eq("bad_pulse_end", 32'(bad_op), 32'd0);
    check_eq("bad_count", 32'(count), 32'd3);
    check_eq("bad_addr", 32'(imem_addr), 32'd3);

    // LUI with rs forced to 0, ack stalled 5 cycles, last address.
    send(MnLui, 5'd5, 5'd7, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_we", 32'(imem_we), 32'd1);
      check_eq("stall_addr", 32'(imem_addr), 32'd3);
      check_eq("stall_word", imem_wdata, 32'h3C07BEEF);
      tick();
    end
    ack_once();
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_ready", 32'(req_ready), 32'd0);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_we", 32'(imem_we), 32'd0);

    // Fifth request while full is ignored.
    send(MnAddi, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
    tick();
    check_eq("fifth_we", 32'(imem_we), 32'd0);
    check_eq("fifth_count", 32'(count), 32'd4);
    check_eq("fifth_full", 32'(full), 32'd1);

    // clear with a simultaneous request: clear wins.
    set_req(MnAddi, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
    clear     = 1'b1;
    req_valid = 1'b1;
    tick();
    clear     = 1'b0;
    req_valid = 1'b0;
    check_eq("clr_full", 32'(full), 32'd0);
    check_eq("clr_ready", 32'(req_ready), 32'd1);
    check_eq("clr_addr", 32'(imem_addr), 32'd0);
    check_eq("clr_count", 32'(count), 32'd0);
    check_eq("clr_we", 32'(imem_we), 32'd0);

    // clear mid-write abandons it.
    send(MnOri, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
    check_eq("ori_word", imem_wdata, 32'h382100FF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("midclr_we", 32'(imem_we), 32'd0);
    check_eq("midclr_count", 32'(count), 32'd0);
    check_eq("midclr_ready", 32'(req_ready), 32'd1);

    // BC1: FP with rs=01000 packs as op/rs/rt/imm.
    send(MnFp, 5'b01000, 5'd1, 5'd9, 5'd9, 6'h3F, 16'h0003, 26'd0);
    check_eq("bc1_word", imem_wdata, 32'h45010003);
    ack_once();

    // Reset mid-write.
    send(MnSw, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
    check_eq("sw_we", 32'(imem_we), 32'd1);
    check_eq("sw_word", imem_wdata, 32'hAFA80004);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
